pump_scheduler: RTL and testbench
=================================

Name: pump_scheduler

Overview:
- Sequences the two tank-fill pumps from the two level sensors: low level I on sensors[0], high level S on sensors[1].
- Adds fill hysteresis, lead/lag rotation of the pumps between fill cycles, and a minimum-off (anti short-cycle) holdoff per pump.
- Latches a fault on the impossible sensor code (S=1, I=0) and holds the pumps off until the sensors read valid again.
- Sits between the sensor inputs and the pump drivers, replacing direct decoding of sensors into pumps.

Parameters:
- MIN_OFF, 4, minimum number of clock cycles a pump output stays low after falling; must be >= 1.
- FAULT_CLR, 3, consecutive valid sensor samples needed to leave FAULT; must be >= 1.
- ROTATE, 1, 1 = swap lead pump at the end of each fill cycle; 0 = pump 0 is always lead.
- CNT_W, 8, width of the holdoff and fault-clear counters; must hold max(MIN_OFF, FAULT_CLR).

Ports:
- clock  input  1  system clock, all state on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sensors  input  2  [0]=I (water above low level), [1]=S (water above high level).
- enable  input  1  0 forces both pumps off; the state machine keeps tracking.
- pumps  output  2  registered pump drive, [0]=pump 0, [1]=pump 1.
- lead  output  1  index of the current lead pump.
- current_state  output  2  FSM state: FULL=00, FILL_ONE=01, FILL_BOTH=10, FAULT=11.
- fault  output  1  equals (current_state==FAULT), registered.

Behaviour:
- Reset values (next edge with reset=1): current_state=FULL, pumps=00, lead=0, fault=0. Both holdoff counters and the fault counter clear to 0. Reset mid-fill aborts immediately with no holdoff applied.
- Sensors are sampled every edge. The state updates one edge after a sensor change. pumps update on the same edge as the state.
- Transitions from FULL: 00 -> FILL_BOTH; 01 -> FULL (hysteresis, no refill until below I); 11 -> FULL.
- Transitions from FILL_BOTH: 00 -> stay; 01 -> FILL_ONE; 11 -> FULL.
- Transitions from FILL_ONE: 00 -> FILL_BOTH; 01 -> stay; 11 -> FULL.
- Any non-FAULT state with sensors=10 -> FAULT. Entering FAULT clears the fault counter.
- Inside FAULT, on each edge:
  - sensors=10: counter <= 0.
  - Otherwise, if counter == FAULT_CLR-1: exit to FILL_BOTH (00), FILL_ONE (01) or FULL (11), and counter <= 0.
  - Otherwise: counter increments.
- Demand per state: FULL 00; FILL_ONE only pumps[lead]; FILL_BOTH 11; FAULT 00. Demand is computed from the next state. enable=0 forces demand to 00.
- Holdoff gating, pump i:
  - If pumps[i]=1, pumps[i] <= demand[i].
  - If pumps[i]=0, pumps[i] <= demand[i] AND holdoff[i]==0.
- Holdoff counter, pump i:
  - On a 1->0 edge of pumps[i], load MIN_OFF-1.
  - Otherwise decrement while nonzero.
  - Result: every pump low pulse lasts >= MIN_OFF cycles.
- Rotation: when ROTATE=1, lead toggles on the same edge the state enters FULL from FILL_ONE or FILL_BOTH. It does not toggle on FAULT->FULL or on reset.
- Simultaneous reset and any other event: reset wins.

Test Plan:
1. Reset, sensors=00, enable=1 -> one edge later current_state=10, pumps=11, lead=0, fault=0.
2. Fill cycle 00->01->11 -> pumps 11 -> 01 (lead pump 0) -> 00, state 10->01->00, lead=1 on the FULL edge. Then 01 -> state stays 00, pumps 00.
3. Holdoff (MIN_OFF=4): in FILL_BOTH lead=0, sensors 01 then back to 00 one cycle later. pumps[1] falls, stays 0 for exactly 4 cycles, then rises. pumps[0] stays 1 throughout.
4. Fault (FAULT_CLR=3): sensors=10 in FILL_BOTH -> next edge state=11, pumps=00, fault=1. Sensor sequence 11,11,10,11,11,11 -> state=00 and fault=0 only after the final 11.
5. enable=0 in FILL_BOTH -> next edge pumps=00 while state stays 10. enable=1 -> pumps=11 after exactly 4 low cycles.
6. ROTATE=0: two complete fill cycles -> lead stays 0, FILL_ONE always drives pumps=01. Reset asserted mid-FILL_ONE -> next edge pumps=00, state=00, lead=0.

Source files
------------

// File: rtl/pump_scheduler.sv
// rtl/pump_scheduler.sv - two-pump tank fill scheduler with hysteresis, lead/lag rotation, holdoff and sensor fault latch
module pump_scheduler #(
  parameter int MIN_OFF   = 4,
  parameter int FAULT_CLR = 3,
  parameter int ROTATE    = 1,
  parameter int CNT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] sensors,
  input  logic       enable,
  output logic [1:0] pumps,
  output logic       lead,
  output logic [1:0] current_state,
  output logic       fault
);

  typedef enum logic [1:0] {
    FULL      = 2'b00,
    FILL_ONE  = 2'b01,
    FILL_BOTH = 2'b10,
    FAULTED   = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] fault_cnt;
  logic [CNT_W-1:0] fault_cnt_next;
  logic [CNT_W-1:0] holdoff [2];
  logic [1:0]       demand;
  logic [1:0]       pumps_next;
  logic             lead_next;

  assign current_state = state;

  always_comb begin
    state_next     = state;
    fault_cnt_next = '0;
    if (state == FAULTED) begin
      if (sensors != 2'b10) begin
        if (fault_cnt == CNT_W'(FAULT_CLR - 1)) begin
          case (sensors)
            2'b00:   state_next = FILL_BOTH;
            2'b01:   state_next = FILL_ONE;
            default: state_next = FULL;
          endcase
        end else begin
          fault_cnt_next = fault_cnt + 1'b1;
        end
      end
    end else begin
      case (sensors)
        2'b00:   state_next = FILL_BOTH;
        // Hysteresis: between I and S we only keep filling if already filling.
        2'b01:   state_next = (state == FULL) ? FULL : FILL_ONE;
        2'b10:   state_next = FAULTED;
        default: state_next = FULL;
      endcase
    end
  end

  always_comb begin
    demand = 2'b00;
    case (state_next)
      FILL_BOTH: demand = 2'b11;
      FILL_ONE:  demand = lead ? 2'b10 : 2'b01;
      default:   demand = 2'b00;
    endcase
    if (!enable) demand = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pumps_next[i] = pumps[i] ? demand[i] : (demand[i] && (holdoff[i] == '0));
    end
    lead_next = lead;
    if ((ROTATE != 0) && (state_next == FULL) &&
        ((state == FILL_ONE) || (state == FILL_BOTH))) begin
      lead_next = ~lead;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FULL;
      fault_cnt <= '0;
      pumps     <= 2'b00;
      lead      <= 1'b0;
      fault     <= 1'b0;
      for (int i = 0; i < 2; i++) holdoff[i] <= '0;
    end else begin
      state     <= state_next;
      fault_cnt <= fault_cnt_next;
      pumps     <= pumps_next;
      lead      <= lead_next;
      fault     <= (state_next == FAULTED);
      // A falling pump output arms its holdoff; the gate above reads it next edge.
      for (int i = 0; i < 2; i++) begin
        if (pumps[i] && !pumps_next[i]) holdoff[i] <= CNT_W'(MIN_OFF - 1);
        else if (holdoff[i] != '0)      holdoff[i] <= holdoff[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pump_scheduler.sv
// tb/tb_pump_scheduler.sv - randomized and directed bench for pump_scheduler against a behavioural model
module tb_pump_scheduler;

  localparam int MIN_OFF   = 4;
  localparam int FAULT_CLR = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sensors = 2'b00;
  logic       enable = 1'b1;
  logic [1:0] pumps_r, pumps_n;
  logic       lead_r, lead_n;
  logic [1:0] state_r, state_n;
  logic       fault_r, fault_n;

  int n_checks = 0;
  int n_errors = 0;

  // model state per instance: 0 = rotating, 1 = fixed lead
  int m_state [2];
  int m_pumps [2][2];
  int m_age   [2][2];
  int m_lead  [2];
  int m_good  [2];

  always #5 clock = ~clock;

  pump_scheduler #(.MIN_OFF(MIN_OFF), .FAULT_CLR(FAULT_CLR), .ROTATE(1), .CNT_W(8)) dut_rot (
    .clock(clock), .reset(reset), .sensors(sensors), .enable(enable),
    .pumps(pumps_r), .lead(lead_r), .current_state(state_r), .fault(fault_r));

  pump_scheduler #(.MIN_OFF(MIN_OFF), .FAULT_CLR(FAULT_CLR), .ROTATE(0), .CNT_W(8)) dut_fix (
    .clock(clock), .reset(reset), .sensors(sensors), .enable(enable),
    .pumps(pumps_n), .lead(lead_n), .current_state(state_n), .fault(fault_n));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int ns;
    int want [2];
    if (reset) begin
      m_state[k] = 0; m_lead[k] = 0; m_good[k] = 0;
      for (int i = 0; i < 2; i++) begin m_pumps[k][i] = 0; m_age[k][i] = MIN_OFF; end
      return;
    end
    ns = m_state[k];
    if (m_state[k] == 3) begin
      if (sensors == 2'b10) m_good[k] = 0;
      else begin
        m_good[k]++;
        if (m_good[k] == FAULT_CLR) begin
          m_good[k] = 0;
          ns = (sensors == 2'b00) ? 2 : (sensors == 2'b01) ? 1 : 0;
        end
      end
    end else if (sensors == 2'b10) begin
      ns = 3; m_good[k] = 0;
    end else if (sensors == 2'b11) ns = 0;
    else if (sensors == 2'b00) ns = 2;
    else ns = (m_state[k] == 0) ? 0 : 1;
    for (int i = 0; i < 2; i++) begin
      want[i] = enable && ((ns == 2) || (ns == 1 && i == m_lead[k]));
      if (m_pumps[k][i] != 0) begin
        if (!want[i]) begin m_pumps[k][i] = 0; m_age[k][i] = 1; end
      end else begin
        if (want[i] && m_age[k][i] >= MIN_OFF) m_pumps[k][i] = 1;
        else if (m_age[k][i] < MIN_OFF) m_age[k][i]++;
      end
    end
    if (k == 0 && ns == 0 && (m_state[k] == 1 || m_state[k] == 2)) m_lead[k] ^= 1;
    m_state[k] = ns;
  endtask

  task automatic compare_all();
    check("state_rot", 8'(state_r), 8'(m_state[0]));
    check("pumps_rot", 8'(pumps_r), 8'({m_pumps[0][1] != 0, m_pumps[0][0] != 0}));
    check("lead_rot",  8'(lead_r),  8'(m_lead[0]));
    check("fault_rot", 8'(fault_r), 8'(m_state[0] == 3));
    check("state_fix", 8'(state_n), 8'(m_state[1]));
    check("pumps_fix", 8'(pumps_n), 8'({m_pumps[1][1] != 0, m_pumps[1][0] != 0}));
    check("lead_fix",  8'(lead_n),  8'(m_lead[1]));
    check("fault_fix", 8'(fault_n), 8'(m_state[1] == 3));
  endtask

  task automatic cycle(input logic [1:0] s, input logic e, input logic r);
    sensors = s; enable = e; reset = r;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  initial begin
    logic [1:0] s;
    int hold;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_lead[k] = 0; m_good[k] = 0;
      for (int i = 0; i < 2; i++) begin m_pumps[k][i] = 0; m_age[k][i] = MIN_OFF; end
    end
    cycle(2'b00, 1'b1, 1'b1);
    check("reset_state", 8'(state_r), 8'h0);
    check("reset_pumps", 8'(pumps_r), 8'h0);

    // basic fill cycle
    cycle(2'b00, 1'b1, 1'b0);
    check("t1_state", 8'(state_r), 8'h2);
    check("t1_pumps", 8'(pumps_r), 8'h3);
    cycle(2'b01, 1'b1, 1'b0);
    check("t2_one_pumps", 8'(pumps_r), 8'h1);
    cycle(2'b11, 1'b1, 1'b0);
    check("t2_full_state", 8'(state_r), 8'h0);
    check("t2_full_lead", 8'(lead_r), 8'h1);
    cycle(2'b01, 1'b1, 1'b0);
    check("t2_hyst_state", 8'(state_r), 8'h0);

    // holdoff on pump 1
    cycle(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b01, 1'b1, 1'b0);
    check("t3_fall", 8'(pumps_r), 8'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 1'b1, 1'b0);
      check("t3_held", 8'(pumps_r), 8'h1);
    end
    cycle(2'b00, 1'b1, 1'b0);
    check("t3_rise", 8'(pumps_r), 8'h3);

    // sensor fault and clearing
    cycle(2'b10, 1'b1, 1'b0);
    check("t4_enter", 8'({state_r, pumps_r, 3'b000, fault_r}), 8'hC1);
    cycle(2'b11, 1'b1, 1'b0);
    cycle(2'b11, 1'b1, 1'b0);
    cycle(2'b10, 1'b1, 1'b0);
    cycle(2'b11, 1'b1, 1'b0);
    cycle(2'b11, 1'b1, 1'b0);
    check("t4_still", 8'(state_r), 8'h3);
    cycle(2'b11, 1'b1, 1'b0);
    check("t4_exit", 8'({state_r, fault_r}), 8'h0);

    // enable gating plus holdoff
    cycle(2'b00, 1'b1, 1'b0);
    check("t5_fill", 8'(pumps_r), 8'h3);
    cycle(2'b00, 1'b0, 1'b0);
    check("t5_off", 8'({state_r, pumps_r}), 8'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 1'b1, 1'b0);
      check("t5_held", 8'(pumps_r), 8'h0);
    end
    cycle(2'b00, 1'b1, 1'b0);
    check("t5_rise", 8'(pumps_r), 8'h3);

    // fixed lead over two fill cycles, then reset mid-fill
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 5; i++) cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      cycle(2'b01, 1'b1, 1'b0);
      check("t6_one", 8'(pumps_n), 8'h1);
      cycle(2'b11, 1'b1, 1'b0);
      check("t6_lead", 8'(lead_n), 8'h0);
    end
    for (int i = 0; i < 5; i++) cycle(2'b11, 1'b1, 1'b0);
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b01, 1'b1, 1'b0);
    cycle(2'b01, 1'b1, 1'b1);
    check("t6_reset", 8'({state_n, pumps_n, 3'b000, lead_n}), 8'h0);
    check("t6_reset_rot", 8'(lead_r), 8'h0);

    // random sensor segments with occasional reset and enable drops
    for (int seg = 0; seg < 600; seg++) begin
      case ($urandom_range(0, 9))
        0:       s = 2'b10;
        1, 2, 3: s = 2'b00;
        4, 5, 6: s = 2'b01;
        default: s = 2'b11;
      endcase
      hold = $urandom_range(1, 6);
      for (int i = 0; i < hold; i++)
        cycle(s, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
